// File: rtl/lightshow_pkg.sv
// Shared types and constants for the LED lightshow colour pipeline.
package lightshow_pkg;

   localparam int N_REQ_DEFAULT = 4;

   localparam int R_HI = 23;
   localparam int G_HI = 15;
   localparam int B_HI = 7;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      MUL_R = 3'd1,
      MUL_G = 3'd2,
      MUL_B = 3'd3,
      DONE  = 3'd4
   } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, wrapping.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx
);

   logic [2*N-1:0] req_dbl;
   logic [N-1:0]   rot;
   logic [IW-1:0]  off;
   logic [IW:0]    sum;
   logic           found;

   always_comb begin
      req_dbl = {req, req} >> ptr;
      rot     = req_dbl[N-1:0];
      off     = '0;
      found   = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!found && rot[i]) begin
            found = 1'b1;
            off   = IW'(i);
         end
      end
      // rotate the offset back into requester numbering, modulo N
      sum = {1'b0, ptr} + {1'b0, off};
      if (sum >= (IW+1)'(N))
         sum = sum - (IW+1)'(N);
      idx = sum[IW-1:0];
      gnt = found ? (N'(1) << idx) : '0;
   end

endmodule

// File: rtl/power_scale_sched.sv
// Shares one 8x8 multiplier among N_REQ colour requesters, scaling each
// snapshot colour by sig_power one channel per cycle.
//
// state | meaning
// IDLE  | no service in progress, arbitrating on req
// MUL_R | scaling red byte of the snapshot colour
// MUL_G | scaling green byte
// MUL_B | scaling blue byte, result register loaded at end of cycle
// DONE  | result presented; re-arbitrate for a back-to-back start
module power_scale_sched
   import lightshow_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEFAULT,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N_REQ-1:0]      req,
   input  logic [24*N_REQ-1:0]   req_color,
   input  logic [7:0]            sig_power,
   output logic [N_REQ-1:0]      gnt,
   output logic                  res_valid,
   output logic [ID_W-1:0]       res_id,
   output logic [23:0]           res_color,
   output logic                  busy
);

   sched_state_t     state, state_nxt;
   logic [ID_W-1:0]  ptr, id_s, id_inc, arb_ptr, arb_idx;
   logic [N_REQ-1:0] arb_gnt;
   logic [23:0]      col_s, col_sel;
   logic [7:0]       pow_s, acc_r, acc_g, mul_a, prod_hi;
   logic             start;

   assign id_inc  = (id_s == ID_W'(N_REQ-1)) ? '0 : id_s + ID_W'(1);
   // in DONE the pointer update is still in flight, so arbitrate on its next value
   assign arb_ptr = (state == DONE) ? id_inc : ptr;
   assign start   = ((state == IDLE) || (state == DONE)) && (|req);

   rr_arbiter #(.N(N_REQ), .IW(ID_W)) u_arb (
      .req (req),
      .ptr (arb_ptr),
      .gnt (arb_gnt),
      .idx (arb_idx)
   );

   always_comb begin
      col_sel = '0;
      for (int i = 0; i < N_REQ; i++)
         if (arb_gnt[i])
            col_sel = col_sel | req_color[24*i +: 24];
   end

   always_comb begin
      case (state)
         MUL_R:   mul_a = col_s[R_HI -: 8];
         MUL_G:   mul_a = col_s[G_HI -: 8];
         default: mul_a = col_s[B_HI -: 8];
      endcase
      prod_hi = 8'((16'(mul_a) * 16'(pow_s)) >> 8);
   end

   always_comb begin
      case (state)
         IDLE:    state_nxt = (|req) ? MUL_R : IDLE;
         MUL_R:   state_nxt = MUL_G;
         MUL_G:   state_nxt = MUL_B;
         MUL_B:   state_nxt = DONE;
         DONE:    state_nxt = (|req) ? MUL_R : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         ptr       <= '0;
         id_s      <= '0;
         col_s     <= '0;
         pow_s     <= '0;
         acc_r     <= '0;
         acc_g     <= '0;
         res_color <= '0;
         res_id    <= '0;
      end else begin
         state <= state_nxt;
         if (start) begin
            col_s <= col_sel;
            pow_s <= sig_power;
            id_s  <= arb_idx;
         end
         if (state == DONE)
            ptr <= id_inc;
         case (state)
            MUL_R: acc_r <= prod_hi;
            MUL_G: acc_g <= prod_hi;
            // output register only moves here, so res_color holds between results
            MUL_B: begin
               res_color <= {acc_r, acc_g, prod_hi};
               res_id    <= id_s;
            end
            default: ;
         endcase
      end
   end

   assign busy      = (state != IDLE);
   assign res_valid = (state == DONE);
   assign gnt       = ((state == MUL_R) || (state == MUL_G) || (state == MUL_B))
                      ? (N_REQ'(1) << id_s) : '0;

endmodule

// File: tb/tb_power_scale_sched.sv
// Directed bench for power_scale_sched: reset, round robin, arithmetic edges,
// snapshot isolation and mid-service reset.
module tb_power_scale_sched;

   logic        clk;
   logic        reset;
   logic [3:0]  req;
   logic [95:0] req_color;
   logic [7:0]  sig_power;
   logic [3:0]  gnt;
   logic        res_valid;
   logic [1:0]  res_id;
   logic [23:0] res_color;
   logic        busy;

   int checks = 0;
   int errors = 0;

   power_scale_sched #(.N_REQ(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .req_color (req_color),
      .sig_power (sig_power),
      .gnt       (gnt),
      .res_valid (res_valid),
      .res_id    (res_id),
      .res_color (res_color),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_col(input int id, input logic [23:0] c);
      req_color[24*id +: 24] = c;
   endtask

   // caller has req/colours/power set up in IDLE; the first edge here is the grant edge
   task automatic service(input int id, input logic [23:0] exp, input bit scramble);
      step();
      req = 4'b0000;
      if (scramble) begin
         req_color = '1;
         sig_power = 8'hFF;
      end
      for (int c = 0; c < 3; c++) begin
         check("svc_gnt", 32'(gnt), 32'(4'b0001 << id));
         check("svc_busy", 32'(busy), 32'd1);
         check("svc_noval", 32'(res_valid), 32'd0);
         step();
      end
      check("done_valid", 32'(res_valid), 32'd1);
      check("done_id", 32'(res_id), 32'(id));
      check("done_color", 32'(res_color), 32'(exp));
      check("done_gnt", 32'(gnt), 32'd0);
      step();
      check("after_valid", 32'(res_valid), 32'd0);
      check("after_busy", 32'(busy), 32'd0);
      check("after_gnt", 32'(gnt), 32'd0);
      check("after_hold", 32'(res_color), 32'(exp));
   endtask

   initial begin
      logic [23:0] rr_exp [4];
      rr_exp[0] = 24'h113355;
      rr_exp[1] = 24'h7F3FFE;
      rr_exp[2] = 24'hFEFEFE;
      rr_exp[3] = 24'h000000;

      reset     = 1'b1;
      req       = 4'b1111;
      sig_power = 8'hFF;
      req_color = '0;
      set_col(0, 24'h123456);
      set_col(1, 24'h8040FF);
      set_col(2, 24'hFFFFFF);
      set_col(3, 24'h000001);

      for (int c = 0; c < 3; c++) begin
         step();
         check("rst_gnt", 32'(gnt), 32'd0);
         check("rst_valid", 32'(res_valid), 32'd0);
         check("rst_color", 32'(res_color), 32'd0);
         check("rst_busy", 32'(busy), 32'd0);
      end
      reset = 1'b0;

      // all four held: ids 0,1,2,3,0 with a result every fourth cycle
      for (int c = 1; c <= 20; c++) begin
         step();
         if (c % 4 == 0) begin
            check("rr_valid", 32'(res_valid), 32'd1);
            check("rr_id", 32'(res_id), 32'((c/4 - 1) % 4));
            check("rr_color", 32'(res_color), 32'(rr_exp[(c/4 - 1) % 4]));
            check("rr_gnt0", 32'(gnt), 32'd0);
         end else begin
            check("rr_novalid", 32'(res_valid), 32'd0);
            check("rr_gnt", 32'(gnt), 32'(4'b0001 << (((c-1)/4) % 4)));
         end
      end
      req = 4'b0000;
      step();
      check("rr_idle", 32'(busy), 32'd0);

      req = 4'b0010;
      set_col(1, 24'h8040FF);
      sig_power = 8'h80;
      service(1, 24'h40207F, 1'b0);

      req = 4'b0100;
      set_col(2, 24'hFFFFFF);
      sig_power = 8'hFF;
      service(2, 24'hFEFEFE, 1'b0);

      req = 4'b0100;
      sig_power = 8'h00;
      service(2, 24'h000000, 1'b0);

      // colour/power scrambled and req[0] dropped right after the grant edge
      req = 4'b0001;
      set_col(0, 24'h204060);
      sig_power = 8'h40;
      service(0, 24'h081018, 1'b1);
      step();
      check("snap_nogrant", 32'(gnt), 32'd0);
      check("snap_idle", 32'(busy), 32'd0);

      req_color = '0;
      set_col(3, 24'h808080);
      sig_power = 8'hFF;
      req = 4'b1000;
      step();
      check("mr_gnt_r", 32'(gnt), 32'b1000);
      step();
      check("mr_gnt_g", 32'(gnt), 32'b1000);
      #2;
      reset = 1'b1;
      #1;
      check("mr_gnt", 32'(gnt), 32'd0);
      check("mr_busy", 32'(busy), 32'd0);
      check("mr_valid", 32'(res_valid), 32'd0);
      check("mr_color", 32'(res_color), 32'd0);
      check("mr_id", 32'(res_id), 32'd0);
      for (int c = 0; c < 2; c++) begin
         step();
         check("mr_hold_valid", 32'(res_valid), 32'd0);
         check("mr_hold_busy", 32'(busy), 32'd0);
      end
      reset = 1'b0;
      service(3, 24'h7F7F7F, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
